// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin channel arbiter.
// Grant state encoding is fixed so downstream debug decoders can rely on it.
package mux2_rr_arbiter_pkg;

  localparam int MAX_BEATS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester/sink handshake bundle for mux2_rr_arbiter.
// master = producers and sink side, slave = the arbiter itself.
interface mux2_rr_arbiter_if;

  logic       req_a;
  logic [1:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [1:0] data_b;
  logic       ack_b;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic       grant_a;
  logic       grant_b;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, out_valid, out_data, grant_a, grant_b
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, out_valid, out_data, grant_a, grant_b
  );

endinterface

// File: rtl/mux2_rr_arbiter_mux2.sv
// Plain 2-bit 2:1 multiplexer for the shared output channel.
module mux2_rr_arbiter_mux2 (
  input  logic       sel,
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  output logic [1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of one 2-bit channel shared by requesters A and B,
// with bursts capped at MAX_BEATS transfers per grant.
//
// state | meaning
// IDLE  | no owner, arbitrate pending requests (tie goes opposite of last_b)
// GNT_A | A owns the channel, beats counted in beat_cnt
// GNT_B | B owns the channel, beats counted in beat_cnt
import mux2_rr_arbiter_pkg::*;

module mux2_rr_arbiter #(
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input logic               clk,
  input logic               rst,
  mux2_rr_arbiter_if.slave  bus
);

  localparam int             CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             last_b, last_b_nxt;

  logic       grant_a, grant_b;
  logic       own_req, other_req, xfer;
  arb_state_t other_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      last_b   <= last_b_nxt;
    end
  end

  assign grant_a   = (state == GNT_A);
  assign grant_b   = (state == GNT_B);
  assign own_req   = (grant_a & bus.req_a) | (grant_b & bus.req_b);
  assign other_req = grant_b ? bus.req_a : bus.req_b;
  assign other_st  = grant_b ? GNT_A : GNT_B;
  assign xfer      = own_req & bus.out_ready;

  assign bus.grant_a   = grant_a;
  assign bus.grant_b   = grant_b;
  assign bus.out_valid = own_req;
  assign bus.ack_a     = grant_a & bus.req_a & bus.out_ready;
  assign bus.ack_b     = grant_b & bus.req_b & bus.out_ready;

  mux2_rr_arbiter_mux2 u_mux (
    .sel (grant_b),
    .d0  (bus.data_a),
    .d1  (bus.data_b),
    .y   (bus.out_data)
  );

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    last_b_nxt   = last_b;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_nxt = last_b ? GNT_A : GNT_B;
        else if (bus.req_a)         state_nxt = GNT_A;
        else if (bus.req_b)         state_nxt = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (!own_req) begin
          // Owner dropped its request: any unused beats are forfeited.
          state_nxt    = other_req ? other_st : IDLE;
          beat_cnt_nxt = '0;
          last_b_nxt   = grant_b;
        end else if (xfer) begin
          if (beat_cnt == LAST_BEAT) begin
            // Burst cap reached; keep the grant only if nobody else waits.
            if (other_req) state_nxt = other_st;
            beat_cnt_nxt = '0;
            last_b_nxt   = grant_b;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed vector table, corner
// sequences, then random traffic against a rule-level ownership model.
module tb_mux2_rr_arbiter;

  localparam int MAXB = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mux2_rr_arbiter_if bus ();

  mux2_rr_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ra, rb;
    logic [1:0] da, db;
    logic       rdy;
    logic       ga, gb, v, aa, ab;
    logic [1:0] od;
  } vec_t;

  vec_t vecs[21];

  // Rule-level model: who owns the channel, beats spent, whose turn on a tie.
  int m_owner;   // 0 none, 1 A, 2 B
  int m_used;
  int m_pref_a;

  function automatic vec_t mk(input int ra, rb, da, db, rdy, ga, gb, v, aa, ab, od);
    vec_t r;
    r.ra = ra[0]; r.rb = rb[0]; r.da = da[1:0]; r.db = db[1:0]; r.rdy = rdy[0];
    r.ga = ga[0]; r.gb = gb[0]; r.v = v[0]; r.aa = aa[0]; r.ab = ab[0]; r.od = od[1:0];
    return r;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ra, rb, input logic [1:0] da, db, input logic rdy);
    bus.req_a = ra; bus.req_b = rb; bus.data_a = da; bus.data_b = db; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk1("rst_grant_a", bus.grant_a, 1'b0);
    chk1("rst_grant_b", bus.grant_b, 1'b0);
    chk1("rst_valid",   bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_owner = 0; m_used = 0; m_pref_a = 1;
  endtask

  task automatic model_check(input string tag);
    logic ga, gb, v;
    ga = (m_owner == 1);
    gb = (m_owner == 2);
    v  = (ga & bus.req_a) | (gb & bus.req_b);
    chk1({tag, "_grant_a"}, bus.grant_a, ga);
    chk1({tag, "_grant_b"}, bus.grant_b, gb);
    chk1({tag, "_valid"},   bus.out_valid, v);
    chk1({tag, "_ack_a"},   bus.ack_a, ga & bus.req_a & bus.out_ready);
    chk1({tag, "_ack_b"},   bus.ack_b, gb & bus.req_b & bus.out_ready);
    chk2({tag, "_data"},    bus.out_data, gb ? bus.data_b : bus.data_a);
  endtask

  task automatic model_advance();
    bit own, oth;
    if (m_owner == 0) begin
      if (bus.req_a && bus.req_b) m_owner = m_pref_a ? 1 : 2;
      else if (bus.req_a)         m_owner = 1;
      else if (bus.req_b)         m_owner = 2;
    end else begin
      own = (m_owner == 1) ? bus.req_a : bus.req_b;
      oth = (m_owner == 1) ? bus.req_b : bus.req_a;
      if (!own) begin
        m_pref_a = (m_owner == 2);
        m_owner  = oth ? 3 - m_owner : 0;
        m_used   = 0;
      end else if (bus.out_ready) begin
        m_used++;
        if (m_used == MAXB) begin
          m_pref_a = (m_owner == 2);
          if (oth) m_owner = 3 - m_owner;
          m_used = 0;
        end
      end
    end
  endtask

  initial begin
    int n_a, n_b;
    logic [1:0] held;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    //            ra rb da db rdy  ga gb v aa ab od
    vecs[0]  = mk(1, 0, 2, 0, 1,   0, 0, 0, 0, 0, 2);
    vecs[1]  = mk(1, 0, 2, 0, 1,   1, 0, 1, 1, 0, 2);
    vecs[2]  = mk(1, 0, 2, 0, 1,   1, 0, 1, 1, 0, 2);
    vecs[3]  = mk(1, 0, 2, 0, 1,   1, 0, 1, 1, 0, 2);
    vecs[4]  = mk(0, 0, 2, 0, 1,   1, 0, 0, 0, 0, 2);
    vecs[5]  = mk(0, 0, 2, 1, 1,   0, 0, 0, 0, 0, 2);
    vecs[6]  = mk(1, 1, 1, 3, 1,   0, 0, 0, 0, 0, 1);
    vecs[7]  = mk(1, 1, 1, 3, 1,   0, 1, 1, 0, 1, 3);
    vecs[8]  = mk(1, 1, 1, 3, 0,   0, 1, 1, 0, 0, 3);
    vecs[9]  = mk(1, 1, 1, 3, 1,   0, 1, 1, 0, 1, 3);
    vecs[10] = mk(1, 1, 1, 3, 1,   0, 1, 1, 0, 1, 3);
    vecs[11] = mk(1, 1, 1, 3, 1,   0, 1, 1, 0, 1, 3);
    vecs[12] = mk(1, 1, 1, 3, 1,   1, 0, 1, 1, 0, 1);
    vecs[13] = mk(0, 1, 1, 2, 1,   1, 0, 0, 0, 0, 1);
    vecs[14] = mk(0, 1, 1, 2, 1,   0, 1, 1, 0, 1, 2);
    vecs[15] = mk(0, 1, 1, 2, 1,   0, 1, 1, 0, 1, 2);
    vecs[16] = mk(0, 1, 1, 2, 1,   0, 1, 1, 0, 1, 2);
    vecs[17] = mk(0, 1, 1, 2, 1,   0, 1, 1, 0, 1, 2);
    vecs[18] = mk(0, 1, 1, 2, 1,   0, 1, 1, 0, 1, 2);
    vecs[19] = mk(0, 0, 1, 2, 1,   0, 1, 0, 0, 0, 2);
    vecs[20] = mk(0, 0, 1, 2, 1,   0, 0, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].db, vecs[i].rdy);
      @(negedge clk);
      chk1($sformatf("vec%0d_grant_a", i), bus.grant_a, vecs[i].ga);
      chk1($sformatf("vec%0d_grant_b", i), bus.grant_b, vecs[i].gb);
      chk1($sformatf("vec%0d_valid", i),   bus.out_valid, vecs[i].v);
      chk1($sformatf("vec%0d_ack_a", i),   bus.ack_a, vecs[i].aa);
      chk1($sformatf("vec%0d_ack_b", i),   bus.ack_b, vecs[i].ab);
      chk2($sformatf("vec%0d_data", i),    bus.out_data, vecs[i].od);
      @(posedge clk);
      #1;
    end

    // Both held: strict 4/4 alternation starting with A, no idle cycle.
    do_reset();
    drive(1'b1, 1'b1, 2'd1, 2'd2, 1'b1);
    @(negedge clk);
    chk1("alt_idle_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk1($sformatf("alt%0d_valid", i), bus.out_valid, 1'b1);
      chk1($sformatf("alt%0d_ack_a", i), bus.ack_a, ((i / MAXB) % 2) == 0);
      chk1($sformatf("alt%0d_ack_b", i), bus.ack_b, ((i / MAXB) % 2) == 1);
      @(posedge clk); #1;
    end

    // Stall mid-burst: ready low must not consume beats.
    do_reset();
    drive(1'b1, 1'b1, 2'd3, 2'd1, 1'b1);
    @(posedge clk); #1;
    n_a = 0; n_b = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); n_a += int'(bus.ack_a); @(posedge clk); #1;
    end
    held = bus.out_data;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("stall%0d_ack_a", i), bus.ack_a, 1'b0);
      chk1($sformatf("stall%0d_grant_a", i), bus.grant_a, 1'b1);
      chk2($sformatf("stall%0d_data", i), bus.out_data, held);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_a += int'(bus.ack_a); n_b += int'(bus.ack_b);
      @(posedge clk); #1;
    end
    chk2("stall_burst_a", 2'(n_a), 2'(MAXB));
    chk1("stall_then_b", n_b == 1, 1'b1);

    // Async reset mid-burst in GNT_B, then fresh arbitration favours A.
    do_reset();
    drive(1'b0, 1'b1, 2'd0, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk1("pre_rst_ack_b", bus.ack_b, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_rst_grant_b", bus.grant_b, 1'b0);
    chk1("async_rst_valid",   bus.out_valid, 1'b0);
    chk1("async_rst_ack_b",   bus.ack_b, 1'b0);
    rst = 1'b0;
    bus.req_a = 1'b1;
    @(negedge clk);
    chk1("post_rst_idle", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post_rst_grant_a", bus.grant_a, 1'b1);
    @(posedge clk); #1;

    // Random traffic against the ownership model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            2'($urandom), 2'($urandom), $urandom_range(0, 9) < 7);
      @(negedge clk);
      model_check("rand");
      model_advance();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
